ariane_uart_tx_sched: RTL

- AXI4-Lite master that configures the ariane_uart 16550-style slave after reset, then schedules a byte stream into it.
- Programs the divisor latch, line control, FIFO control and interrupt enable registers in fixed order.
- Then accepts bytes on a valid/ready port, polls LSR.THRE, and writes THR in bursts sized to the UART TX FIFO.
- Sits in the block design between a console/byte source and the UART's S00_AXI port.

---
 rtl/ariane_uart_tx_sched_if.sv | 38 +++
 rtl/ariane_uart_tx_sched.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ariane_uart_tx_sched_if.sv
// AXI4-Lite bundle between the UART TX scheduler (master) and the ariane_uart S00_AXI port (slave).
interface ariane_uart_tx_sched_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/ariane_uart_tx_sched.sv
// AXI4-Lite master: programs the 16550-style UART after reset, then streams bytes
// into THR in FIFO-sized bursts, each burst unlocked by an LSR.THRE poll.
module ariane_uart_tx_sched #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [15:0]           DIVISOR    = 16'd54,
    parameter logic [7:0]            LCR_VAL    = 8'h03,
    parameter int unsigned           FIFO_BURST = 16,
    parameter int unsigned           POLL_GAP   = 8
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic                   cfg_start_i,
    output logic                   cfg_done_o,
    input  logic [7:0]             tx_data_i,
    input  logic                   tx_valid_i,
    output logic                   tx_ready_o,
    output logic                   err_o,
    ariane_uart_tx_sched_if.master m_axi
);
    localparam int unsigned CW = $clog2(FIFO_BURST + 1);
    localparam int unsigned GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    localparam logic [2:0] CFG_W  = 3'd0;
    localparam logic [2:0] CFG_B  = 3'd1;
    localparam logic [2:0] IDLE   = 3'd2;
    localparam logic [2:0] THR_W  = 3'd3;
    localparam logic [2:0] THR_B  = 3'd4;
    localparam logic [2:0] LSR_AR = 3'd5;
    localparam logic [2:0] LSR_R  = 3'd6;
    localparam logic [2:0] GAP    = 3'd7;

    function automatic logic [7:0] cfg_off(input logic [2:0] i);
        case (i)
            3'd0, 3'd3: cfg_off = 8'h0C;
            3'd1:       cfg_off = 8'h00;
            3'd4:       cfg_off = 8'h08;
            default:    cfg_off = 8'h04;
        endcase
    endfunction

    function automatic logic [7:0] cfg_val(input logic [2:0] i);
        case (i)
            3'd0:    cfg_val = 8'h80;
            3'd1:    cfg_val = DIVISOR[7:0];
            3'd2:    cfg_val = DIVISOR[15:8];
            3'd3:    cfg_val = LCR_VAL;
            3'd4:    cfg_val = 8'h07;
            default: cfg_val = 8'h00;
        endcase
    endfunction

    logic [2:0]    state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [CW-1:0] credit_q, credit_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          issued_q, issued_d;
    logic          awvalid_q, awvalid_d;
    logic          wvalid_q, wvalid_d;
    logic          bready_q, bready_d;
    logic          arvalid_q, arvalid_d;
    logic          rready_q, rready_d;
    logic          cfg_done_q, cfg_done_d;
    logic          err_q, err_d;
    logic          byte_ld;
    logic [7:0]    byte_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        credit_d   = credit_q;
        gap_d      = gap_q;
        issued_d   = issued_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        cfg_done_d = cfg_done_q;
        err_d      = err_q;
        byte_ld    = 1'b0;
        case (state_q)
            CFG_W, THR_W: begin
                // issued_q is only clear here on the first cycle out of reset
                if (!issued_q) begin
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    issued_d  = 1'b1;
                end else begin
                    if (awvalid_q && m_axi.awready) awvalid_d = 1'b0;
                    if (wvalid_q && m_axi.wready)   wvalid_d  = 1'b0;
                    if (!awvalid_d && !wvalid_d) begin
                        issued_d = 1'b0;
                        bready_d = 1'b1;
                        state_d  = (state_q == CFG_W) ? CFG_B : THR_B;
                    end
                end
            end
            CFG_B: begin
                if (m_axi.bvalid) begin
                    bready_d = 1'b0;
                    if (m_axi.bresp != 2'b00) err_d = 1'b1;
                    if (idx_q == 3'd5) begin
                        cfg_done_d = 1'b1;
                        credit_d   = '0;
                        state_d    = IDLE;
                    end else begin
                        idx_d     = idx_q + 3'd1;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        issued_d  = 1'b1;
                        state_d   = CFG_W;
                    end
                end
            end
            IDLE: begin
                if (cfg_start_i) begin
                    err_d      = 1'b0;
                    cfg_done_d = 1'b0;
                    idx_d      = '0;
                    awvalid_d  = 1'b1;
                    wvalid_d   = 1'b1;
                    issued_d   = 1'b1;
                    state_d    = CFG_W;
                end else if (tx_valid_i && tx_ready_o) begin
                    byte_ld   = 1'b1;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    issued_d  = 1'b1;
                    state_d   = THR_W;
                end else if (tx_valid_i && credit_q == '0) begin
                    arvalid_d = 1'b1;
                    state_d   = LSR_AR;
                end
            end
            LSR_AR: begin
                if (m_axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = LSR_R;
                end
            end
            LSR_R: begin
                if (m_axi.rvalid) begin
                    rready_d = 1'b0;
                    if (m_axi.rresp != 2'b00) err_d = 1'b1;
                    // an errored read never grants credit
                    if (m_axi.rdata[5] && m_axi.rresp == 2'b00) begin
                        credit_d = CW'(FIFO_BURST);
                        state_d  = IDLE;
                    end else if (POLL_GAP == 0) begin
                        arvalid_d = 1'b1;
                        state_d   = LSR_AR;
                    end else begin
                        gap_d   = '0;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_q == GW'(POLL_GAP - 1)) begin
                    arvalid_d = 1'b1;
                    state_d   = LSR_AR;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            THR_B: begin
                if (m_axi.bvalid) begin
                    bready_d = 1'b0;
                    if (m_axi.bresp != 2'b00) err_d = 1'b1;
                    if (credit_q != '0) credit_d = credit_q - CW'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = CFG_W;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q    <= CFG_W;
            idx_q      <= '0;
            credit_q   <= '0;
            gap_q      <= '0;
            issued_q   <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            cfg_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            credit_q   <= credit_d;
            gap_q      <= gap_d;
            issued_q   <= issued_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            cfg_done_q <= cfg_done_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge ACLK) begin
        if (byte_ld) byte_q <= tx_data_i;
    end

    assign m_axi.awaddr  = BASE_ADDR + ADDR_WIDTH'((state_q == THR_W) ? 8'h00 : cfg_off(idx_q));
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = {24'h0, (state_q == THR_W) ? byte_q : cfg_val(idx_q)};
    assign m_axi.wstrb   = 4'hF;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.araddr  = BASE_ADDR + ADDR_WIDTH'(8'h14);
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;

    assign cfg_done_o = cfg_done_q;
    assign err_o      = err_q;
    assign tx_ready_o = (state_q == IDLE) && cfg_done_q && (credit_q != '0);
endmodule
